// File: rtl/mips_pkg.sv
// Shared issue-stage definitions: latency classes per functional unit,
// hazard-cause encoding and the latency clamp used by the scoreboard.
package mips_pkg;

  localparam int MAXLAT_DEF = 8;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 4;
  localparam int LAT_DIV  = MAXLAT_DEF;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_RAW,
    HZ_WAW,
    HZ_STRUCT
  } hz_cause_e;

  // 0 behaves as a single-cycle op; oversize values saturate.
  function automatic int unsigned lat_clamp(
    input int unsigned l,
    input int unsigned maxlat
  );
    if (l == 0) return 1;
    if (l > maxlat) return maxlat;
    return l;
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue bundle plus the stall/issue/pending responses.
interface issue_scoreboard_if #(
  parameter  int NREGS  = 32,
  parameter  int MAXLAT = 8,
  localparam int AW     = $clog2(NREGS),
  localparam int LW     = $clog2(MAXLAT + 1)
);

  logic             id_iss_valid;
  logic [AW-1:0]    id_iss_addra;
  logic             id_iss_usea;
  logic [AW-1:0]    id_iss_addrb;
  logic             id_iss_useb;
  logic [AW-1:0]    id_iss_regdest;
  logic             id_iss_writereg;
  logic [LW-1:0]    id_iss_latency;
  logic             ex_if_stall;
  logic             iss_stall;
  logic             iss_issue;
  logic [NREGS-1:0] iss_pending;

  modport master (
    output id_iss_valid,
    output id_iss_addra,
    output id_iss_usea,
    output id_iss_addrb,
    output id_iss_useb,
    output id_iss_regdest,
    output id_iss_writereg,
    output id_iss_latency,
    output ex_if_stall,
    input  iss_stall,
    input  iss_issue,
    input  iss_pending
  );

  modport slave (
    input  id_iss_valid,
    input  id_iss_addra,
    input  id_iss_usea,
    input  id_iss_addrb,
    input  id_iss_useb,
    input  id_iss_regdest,
    input  id_iss_writereg,
    input  id_iss_latency,
    input  ex_if_stall,
    output iss_stall,
    output iss_issue,
    output iss_pending
  );

endinterface

// File: rtl/sb_counter.sv
// Cycles-to-writeback counter for one architectural register.
module sb_counter #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [LW-1:0] lat,
  output logic [LW-1:0] cnt
);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (load) begin
        cnt_d = lat;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: per-register countdowns, writeback slot
// bitmap, RAW/WAW/writeback-port hazard detection and issue stall.
module issue_scoreboard
  import mips_pkg::*;
#(
  parameter  int NREGS  = 32,
  parameter  int MAXLAT = MAXLAT_DEF,
  parameter  bit BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS),
  localparam int LW     = $clog2(MAXLAT + 1)
) (
  input logic               clock,
  input logic               reset,
  issue_scoreboard_if.slave sb
);

  localparam logic [LW-1:0] RAW_THR =
    BYPASS ? LW'(1) : '0;

  logic [LW-1:0]   lat;
  logic [LW-1:0]   cnt [NREGS];
  logic [MAXLAT:1] slot_q;
  logic [MAXLAT:1] slot_d;
  logic            we;
  logic            en;
  logic            ld;
  logic            raw_a;
  logic            raw_b;
  logic            waw;
  logic            strc;
  logic            slot_hit;
  logic            stall;
  logic            issue;

  assign lat = LW'(lat_clamp(
    32'(sb.id_iss_latency),
    MAXLAT
  ));

  assign we = sb.id_iss_writereg
    && (sb.id_iss_regdest != '0);
  assign en = !sb.ex_if_stall;

  always_comb begin
    raw_a = sb.id_iss_usea
      && (sb.id_iss_addra != '0)
      && (cnt[sb.id_iss_addra] > RAW_THR);
    raw_b = sb.id_iss_useb
      && (sb.id_iss_addrb != '0)
      && (cnt[sb.id_iss_addrb] > RAW_THR);
    waw = we
      && (cnt[sb.id_iss_regdest] != '0)
      && (cnt[sb.id_iss_regdest] >= lat);
  end

  // Slot L+1 shifts to L next edge, where the new write would land.
  always_comb begin
    slot_hit = 1'b0;
    for (int k = 1; k < MAXLAT; k++) begin
      if (lat == LW'(k)) slot_hit = slot_q[k+1];
    end
    strc = we && slot_hit;
  end

  assign stall = sb.id_iss_valid
    && (raw_a || raw_b || waw || strc);
  assign issue = sb.id_iss_valid
    && !stall && !sb.ex_if_stall;
  assign ld = issue && we;

  assign sb.iss_stall = stall;
  assign sb.iss_issue = issue;

  always_comb begin
    slot_d = slot_q;
    if (en) begin
      for (int k = 1; k < MAXLAT; k++) begin
        slot_d[k] = slot_q[k+1];
      end
      slot_d[MAXLAT] = 1'b0;
      for (int k = 1; k <= MAXLAT; k++) begin
        if (ld && lat == LW'(k)) slot_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    logic ld_r;
    assign ld_r = ld
      && (sb.id_iss_regdest == AW'(r));
    sb_counter #(.LW(LW)) u_cnt (
      .clk  (clock),
      .rst  (reset),
      .en   (en),
      .load (ld_r),
      .lat  (lat),
      .cnt  (cnt[r])
    );
  end

  always_comb begin
    sb.iss_pending = '0;
    for (int r = 0; r < NREGS; r++) begin
      sb.iss_pending[r] = (cnt[r] != '0);
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed scoreboard bench: driver queues expectations, a negedge
// monitor pops and compares. Two DUTs: BYPASS=1 (a) and BYPASS=0 (b).
module tb_issue_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  issue_scoreboard_if #(.NREGS(32), .MAXLAT(8)) if_a ();
  issue_scoreboard_if #(.NREGS(32), .MAXLAT(8)) if_b ();

  issue_scoreboard #(
    .NREGS(32), .MAXLAT(8), .BYPASS(1'b1)
  ) dut_a (
    .clock (clk),
    .reset (rst_a),
    .sb    (if_a)
  );

  issue_scoreboard #(
    .NREGS(32), .MAXLAT(8), .BYPASS(1'b0)
  ) dut_b (
    .clock (clk),
    .reset (rst_b),
    .sb    (if_b)
  );

  typedef struct {
    bit          d;
    bit          rst;
    bit          v;
    logic [4:0]  a;
    bit          ua;
    logic [4:0]  b;
    bit          ub;
    logic [4:0]  dst;
    bit          wr;
    logic [3:0]  lat;
    bit          xs;
    bit          chk;
    bit          es;
    bit          ei;
    logic [31:0] ep;
    string       nm;
  } vec_t;

  typedef struct {
    bit          d;
    bit          es;
    bit          ei;
    logic [31:0] ep;
    string       nm;
  } exp_t;

  vec_t vq[$];
  exp_t eq[$];
  int   n_vec = 0;
  int   n_mis = 0;

  function automatic vec_t base(
    input bit d, input string nm
  );
    vec_t v;
    v.d = d; v.rst = 0; v.v = 0;
    v.a = '0; v.ua = 0; v.b = '0; v.ub = 0;
    v.dst = '0; v.wr = 0; v.lat = '0; v.xs = 0;
    v.chk = 1; v.es = 0; v.ei = 0; v.ep = '0;
    v.nm = nm;
    return v;
  endfunction

  task automatic t_rst(
    input bit d, input bit chk,
    input logic [31:0] ep, input string nm
  );
    vec_t v = base(d, nm);
    v.rst = 1; v.chk = chk; v.ep = ep;
    vq.push_back(v);
  endtask

  task automatic t_idle(
    input bit d, input logic [31:0] ep, input string nm
  );
    vec_t v = base(d, nm);
    v.ep = ep;
    vq.push_back(v);
  endtask

  task automatic t_wr(
    input bit d, input logic [4:0] dst,
    input logic [3:0] lat, input bit xs,
    input bit es, input bit ei,
    input logic [31:0] ep, input string nm
  );
    vec_t v = base(d, nm);
    v.v = 1; v.wr = 1; v.dst = dst; v.lat = lat;
    v.xs = xs; v.es = es; v.ei = ei; v.ep = ep;
    vq.push_back(v);
  endtask

  task automatic t_rd(
    input bit d, input logic [4:0] src,
    input bit portb, input bit xs,
    input bit es, input bit ei,
    input logic [31:0] ep, input string nm
  );
    vec_t v = base(d, nm);
    v.v = 1; v.xs = xs;
    if (portb) begin
      v.b = src; v.ub = 1;
    end else begin
      v.a = src; v.ua = 1;
    end
    v.es = es; v.ei = ei; v.ep = ep;
    vq.push_back(v);
  endtask

  task automatic build();
    // BYPASS=1 unit
    t_rst(0, 0, 32'h0, "rst");
    t_rst(0, 1, 32'h0, "rst_hold");
    t_wr(0, 3, 1, 0, 0, 1, 32'h0, "alu_r3");
    t_rd(0, 3, 0, 0, 0, 1, 32'h8, "byp_r3");
    t_idle(0, 32'h0, "r3_clr");
    t_wr(0, 5, 4, 0, 0, 1, 32'h0, "mul_r5");
    t_rd(0, 5, 0, 0, 1, 0, 32'h20, "raw_c4");
    t_rd(0, 5, 1, 0, 1, 0, 32'h20, "raw_c3");
    t_rd(0, 5, 0, 0, 1, 0, 32'h20, "raw_c2");
    t_rd(0, 5, 1, 0, 0, 1, 32'h20, "raw_c1");
    t_idle(0, 32'h0, "r5_clr");
    t_wr(0, 7, 4, 0, 0, 1, 32'h0, "waw_first");
    for (int i = 0; i < 4; i++)
      t_wr(0, 7, 1, 0, 1, 0, 32'h80, "waw_stall");
    t_wr(0, 7, 1, 0, 0, 1, 32'h0, "waw_go");
    t_idle(0, 32'h80, "r7_l1");
    t_idle(0, 32'h0, "r7_clr");
    t_wr(0, 2, 3, 0, 0, 1, 32'h0, "st_r2");
    t_wr(0, 4, 2, 0, 1, 0, 32'h4, "st_clash");
    t_wr(0, 4, 2, 0, 0, 1, 32'h4, "st_go");
    t_idle(0, 32'h14, "st_both");
    t_idle(0, 32'h10, "st_r4");
    t_idle(0, 32'h0, "st_clr");
    t_wr(0, 6, 3, 0, 0, 1, 32'h0, "hold_r6");
    for (int i = 0; i < 3; i++)
      t_rd(0, 1, 0, 1, 0, 0, 32'h40, "xs_free");
    for (int i = 0; i < 2; i++)
      t_rd(0, 6, 0, 1, 1, 0, 32'h40, "xs_raw");
    for (int i = 0; i < 3; i++)
      t_idle(0, 32'h40, "rel_r6");
    t_idle(0, 32'h0, "r6_clr");
    t_wr(0, 0, 8, 0, 0, 1, 32'h0, "r0_dst");
    t_idle(0, 32'h0, "r0_idle");
    t_wr(0, 9, 5, 0, 0, 1, 32'h0, "r9_l5");
    t_rst(0, 1, 32'h200, "mid_rst");
    t_rd(0, 9, 0, 0, 0, 1, 32'h0, "r9_post");
    t_wr(0, 10, 0, 0, 0, 1, 32'h0, "lat0");
    t_idle(0, 32'h400, "lat0_p");
    t_idle(0, 32'h0, "lat0_clr");
    t_wr(0, 11, 15, 0, 0, 1, 32'h0, "lat15");
    for (int i = 0; i < 8; i++)
      t_idle(0, 32'h800, "lat15_p");
    t_idle(0, 32'h0, "lat15_clr");
    // BYPASS=0 unit
    t_rst(1, 0, 32'h0, "b_rst");
    t_rst(1, 1, 32'h0, "b_rst_hold");
    t_wr(1, 5, 4, 0, 0, 1, 32'h0, "b_mul");
    for (int i = 0; i < 4; i++)
      t_rd(1, 5, 0, 0, 1, 0, 32'h20, "b_raw");
    t_rd(1, 5, 0, 0, 0, 1, 32'h0, "b_go");
  endtask

  task automatic drive(input vec_t v);
    bit ga;
    bit gb;
    ga = !v.d;
    gb = v.d;
    rst_a = ga && v.rst;
    rst_b = gb && v.rst;
    if_a.id_iss_valid    = ga && v.v;
    if_a.id_iss_addra    = v.a;
    if_a.id_iss_usea     = v.ua;
    if_a.id_iss_addrb    = v.b;
    if_a.id_iss_useb     = v.ub;
    if_a.id_iss_regdest  = v.dst;
    if_a.id_iss_writereg = v.wr;
    if_a.id_iss_latency  = v.lat;
    if_a.ex_if_stall     = ga && v.xs;
    if_b.id_iss_valid    = gb && v.v;
    if_b.id_iss_addra    = v.a;
    if_b.id_iss_usea     = v.ua;
    if_b.id_iss_addrb    = v.b;
    if_b.id_iss_useb     = v.ub;
    if_b.id_iss_regdest  = v.dst;
    if_b.id_iss_writereg = v.wr;
    if_b.id_iss_latency  = v.lat;
    if_b.ex_if_stall     = gb && v.xs;
  endtask

  task automatic cmp(
    input string nm, input string fld,
    input logic [31:0] act, input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s.%s: got %h, expected %h",
               nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (eq.size() > 0) begin
      exp_t e;
      logic s;
      logic i;
      logic [31:0] p;
      e = eq.pop_front();
      s = e.d ? if_b.iss_stall : if_a.iss_stall;
      i = e.d ? if_b.iss_issue : if_a.iss_issue;
      p = e.d ? if_b.iss_pending : if_a.iss_pending;
      cmp(e.nm, "stall", 32'(s), 32'(e.es));
      cmp(e.nm, "issue", 32'(i), 32'(e.ei));
      cmp(e.nm, "pending", p, e.ep);
    end
  end

  initial begin
    exp_t e;
    drive(base(0, "init"));
    rst_a = 1'b1;
    rst_b = 1'b1;
    build();
    foreach (vq[n]) begin
      @(posedge clk);
      #1;
      drive(vq[n]);
      if (vq[n].chk) begin
        e.d  = vq[n].d;
        e.es = vq[n].es;
        e.ei = vq[n].ei;
        e.ep = vq[n].ep;
        e.nm = vq[n].nm;
        eq.push_back(e);
      end
    end
    for (int k = 0; k < 4 && eq.size() > 0; k++)
      @(negedge clk);
    #1;
    if (eq.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d left, expected 0",
               eq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
